// File: rtl/arm_fetch_if.sv
// Instruction-memory fetch bus: word read request held until acknowledged.
// ARM_FETCH_ABORT_EN adds the mem_abort response qualifier.
interface arm_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ARM_FETCH_ABORT_EN
    logic        mem_abort;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_abort
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_abort
    );
`else
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
`endif
endinterface

// File: rtl/arm_fetch.sv
// ARM instruction fetch stage: PC, req/ack fetch, instruction register, condition check.
// Optional prefetch-abort support is enabled by defining ARM_FETCH_ABORT_EN.
module arm_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    arm_fetch_if.master        bus,
    input  logic               stall,
    input  logic               pc_we,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        cpsr,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_valid,
`ifdef ARM_FETCH_ABORT_EN
    output logic               prefetch_abort,
`endif
    output logic               cond_pass
);

    localparam logic [31:0] Nop  = 32'hE1A0_0000;
    localparam logic [31:0] Step = 32'(PC_STEP);

    typedef enum logic [1:0] {StFetch, StFlush, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] redir_q;
    logic        req_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        valid_q;
    logic        abort_q;

    logic [31:0] pc_target;
    logic        ack;
    logic        fetch_abort;
    logic        cond_ok;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        unused_bits;

    assign pc_target   = {pc_in[31:2], 2'b00};
    // An ack only counts against a request we actually raised.
    assign ack         = bus.mem_ack & req_q;
    assign unused_bits = ^{cpsr[27:0], pc_in[1:0]};

`ifdef ARM_FETCH_ABORT_EN
    assign fetch_abort    = bus.mem_abort;
    assign prefetch_abort = abort_q;
`else
    assign fetch_abort    = 1'b0;
`endif

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = pc_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign inst_valid   = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            redir_q   <= RESET_PC;
            req_q     <= 1'b0;
            inst_q    <= Nop;
            inst_pc_q <= 32'h0;
            valid_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (!req_q) begin
                        // First cycle after reset: nothing outstanding yet.
                        req_q <= 1'b1;
                        if (pc_we) pc_q <= pc_target;
                    end else if (ack && pc_we) begin
                        pc_q <= pc_target;
                    end else if (ack) begin
                        inst_pc_q <= pc_q;
                        valid_q   <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= StHold;
                        if (fetch_abort) begin
                            inst_q  <= Nop;
                            abort_q <= 1'b1;
                        end else begin
                            inst_q <= bus.mem_rdata;
                            pc_q   <= pc_q + Step;
                        end
                    end else if (pc_we) begin
                        redir_q <= pc_target;
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (ack) begin
                        pc_q    <= pc_we ? pc_target : redir_q;
                        state_q <= StFetch;
                    end else if (pc_we) begin
                        redir_q <= pc_target;
                    end
                end
                StHold: begin
                    if (pc_we) begin
                        valid_q <= 1'b0;
                        abort_q <= 1'b0;
                        pc_q    <= pc_target;
                        req_q   <= 1'b1;
                        state_q <= StFetch;
                    end else if (!stall && !abort_q) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign flag_n = cpsr[31];
    assign flag_z = cpsr[30];
    assign flag_c = cpsr[29];
    assign flag_v = cpsr[28];

    always_comb begin
        cond_ok = 1'b0;
        unique case (inst_q[31:28])
            4'h0: cond_ok = flag_z;
            4'h1: cond_ok = !flag_z;
            4'h2: cond_ok = flag_c;
            4'h3: cond_ok = !flag_c;
            4'h4: cond_ok = flag_n;
            4'h5: cond_ok = !flag_n;
            4'h6: cond_ok = flag_v;
            4'h7: cond_ok = !flag_v;
            4'h8: cond_ok = flag_c && !flag_z;
            4'h9: cond_ok = !flag_c || flag_z;
            4'hA: cond_ok = (flag_n == flag_v);
            4'hB: cond_ok = (flag_n != flag_v);
            4'hC: cond_ok = !flag_z && (flag_n == flag_v);
            4'hD: cond_ok = flag_z || (flag_n != flag_v);
            4'hE: cond_ok = 1'b1;
            4'hF: cond_ok = 1'b0;
            default: cond_ok = 1'b0;
        endcase
    end

    assign cond_pass = valid_q & ~abort_q & cond_ok;

endmodule

// File: tb/tb_arm_fetch.sv
// Self-checking bench for arm_fetch: directed sequences plus a condition-code vector table.
module tb_arm_fetch;

    localparam logic [31:0] Nop = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_we;
    logic [31:0] pc_in;
    logic [31:0] cpsr;
    logic        force_ack;
    logic        abort_in;
    int unsigned wait_states;
    int unsigned wcnt;

    logic [31:0] mem_data [0:127];

    logic [31:0] inst, inst_pc;
    logic        inst_valid, cond_pass;
    logic [31:0] i1_inst, i1_inst_pc;
    logic        i1_valid, i1_cond;
`ifdef ARM_FETCH_ABORT_EN
    logic        prefetch_abort;
    logic        unused_pa1;
`endif

    int passed = 0;
    int total  = 0;

    arm_fetch_if bus0 ();
    arm_fetch_if bus1 ();

    always #5 clk = ~clk;

    // Memory for dut0: programmable wait states, optional forced ack.
    assign bus0.mem_ack   = (bus0.mem_req && (wcnt >= wait_states)) || force_ack;
    assign bus0.mem_rdata = mem_data[bus0.mem_addr[8:2]];
    assign bus1.mem_ack   = bus1.mem_req;
    assign bus1.mem_rdata = mem_data[bus1.mem_addr[8:2]];
`ifdef ARM_FETCH_ABORT_EN
    assign bus0.mem_abort = abort_in;
    assign bus1.mem_abort = 1'b0;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (bus0.mem_req && !bus0.mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    arm_fetch dut0 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus0.master),
        .stall          (stall),
        .pc_we          (pc_we),
        .pc_in          (pc_in),
        .cpsr           (cpsr),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
`ifdef ARM_FETCH_ABORT_EN
        .prefetch_abort (prefetch_abort),
`endif
        .cond_pass      (cond_pass)
    );

    arm_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus1.master),
        .stall          (stall),
        .pc_we          (pc_we),
        .pc_in          (pc_in),
        .cpsr           (cpsr),
        .inst           (i1_inst),
        .inst_pc        (i1_inst_pc),
        .inst_valid     (i1_valid),
`ifdef ARM_FETCH_ABORT_EN
        .prefetch_abort (unused_pa1),
`endif
        .cond_pass      (i1_cond)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] cpsr;
        logic        exp;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect from HOLD to 0x80 and wait for the word placed there to land.
    task automatic load_inst(input logic [31:0] word);
        logic got;
        mem_data[32] = word;
        pc_in = 32'h80;
        pc_we = 1'b1;
        step();
        pc_we = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step();
            if (inst_valid) got = 1'b1;
        end
        check("load_inst arrival", {31'h0, got}, 32'h1);
    endtask

    initial begin
        vecs[0]  = '{32'h0A00_0000, 32'h4000_0000, 1'b1}; // EQ, Z
        vecs[1]  = '{32'h0A00_0000, 32'h0000_0000, 1'b0};
        vecs[2]  = '{32'hCA00_0000, 32'h0000_0000, 1'b1}; // GT
        vecs[3]  = '{32'hCA00_0000, 32'h4000_0000, 1'b0};
        vecs[4]  = '{32'hCA00_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{32'hCA00_0000, 32'h9000_0000, 1'b1};
        vecs[6]  = '{32'hDA00_0000, 32'h0000_0000, 1'b0}; // LE
        vecs[7]  = '{32'hDA00_0000, 32'h4000_0000, 1'b1};
        vecs[8]  = '{32'hDA00_0000, 32'h1000_0000, 1'b1};
        vecs[9]  = '{32'hFA00_0000, 32'hF000_0000, 1'b0}; // NV
        vecs[10] = '{32'hFA00_0000, 32'h0000_0000, 1'b0};
        vecs[11] = '{32'h8A00_0000, 32'h2000_0000, 1'b1}; // HI
        vecs[12] = '{32'h8A00_0000, 32'h6000_0000, 1'b0};
        vecs[13] = '{32'hBA00_0000, 32'h8000_0000, 1'b1}; // LT
        vecs[14] = '{32'hBA00_0000, 32'h9000_0000, 1'b0};
        vecs[15] = '{32'h4A00_0000, 32'h8000_0000, 1'b1}; // MI
        vecs[16] = '{32'h3A00_0000, 32'h2000_0000, 1'b0}; // CC
        vecs[17] = '{32'h1A00_0000, 32'h0000_0000, 1'b1}; // NE

        reset = 1'b1; stall = 1'b1; pc_we = 1'b0; pc_in = '0; cpsr = '0;
        force_ack = 1'b0; abort_in = 1'b0; wait_states = 0;
        for (int i = 0; i < 128; i++) mem_data[i] = Nop;
        mem_data[0]   = 32'hE201_1002;
        mem_data[1]   = 32'hE082_2003;
        mem_data[2]   = 32'hE3A0_0BAD;
        mem_data[64]  = 32'hE3A0_0001;
        mem_data[127] = 32'hE3A0_10AA;

        #12;
        check("reset mem_req", {31'h0, bus0.mem_req}, 32'h0);
        check("reset inst", inst, Nop);
        check("reset inst_pc", inst_pc, 32'h0);
        check("reset inst_valid", {31'h0, inst_valid}, 32'h0);
        check("reset cond_pass", {31'h0, cond_pass}, 32'h0);
        check("reset mem_addr", bus0.mem_addr, 32'h0);

        // Test 1: zero-wait fetch at 0
        @(posedge clk); #1; reset = 1'b0;
        check("first cycle req idle", {31'h0, bus0.mem_req}, 32'h0);
        step();
        check("t1 req", {31'h0, bus0.mem_req}, 32'h1);
        check("t1 addr", bus0.mem_addr, 32'h0);
        check("t1 valid before", {31'h0, inst_valid}, 32'h0);
        check("rpc1 addr", bus1.mem_addr, 32'hFFFF_FFFC);
        step();
        check("t1 inst", inst, 32'hE201_1002);
        check("t1 inst_pc", inst_pc, 32'h0);
        check("t1 valid", {31'h0, inst_valid}, 32'h1);
        check("t1 cond AL", {31'h0, cond_pass}, 32'h1);
        check("t1 addr next", bus0.mem_addr, 32'h4);
        check("rpc1 inst_pc", i1_inst_pc, 32'hFFFF_FFFC);
        check("rpc1 inst", i1_inst, 32'hE3A0_10AA);
        check("rpc1 wrap addr", bus1.mem_addr, 32'h0);

        // Test 3: stall holds the instruction
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall inst", inst, 32'hE201_1002);
            check("stall valid", {31'h0, inst_valid}, 32'h1);
            check("stall req", {31'h0, bus0.mem_req}, 32'h0);
        end
        stall = 1'b0;
        step();
        stall = 1'b1;
        check("unstall req", {31'h0, bus0.mem_req}, 32'h1);
        check("unstall addr", bus0.mem_addr, 32'h4);
        check("unstall valid", {31'h0, inst_valid}, 32'h0);
        check("rpc1 req at 0", {31'h0, bus1.mem_req}, 32'h1);
        check("rpc1 second fetch", bus1.mem_addr, 32'h0);
        step();
        check("t3 inst", inst, 32'hE082_2003);
        check("t3 inst_pc", inst_pc, 32'h4);
        check("t3 addr", bus0.mem_addr, 32'h8);

        // Test 4: redirect during a 3-wait-state fetch
        wait_states = 3;
        stall = 1'b0;
        step();
        stall = 1'b1;
        check("t4 req", {31'h0, bus0.mem_req}, 32'h1);
        pc_we = 1'b1; pc_in = 32'h0000_0103;
        step();
        pc_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4 addr held", bus0.mem_addr, 32'h8);
            check("t4 req held", {31'h0, bus0.mem_req}, 32'h1);
            check("t4 no valid", {31'h0, inst_valid}, 32'h0);
            if (i < 2) step();
        end
        wait_states = 0;
        step();
        check("t4 redirect addr", bus0.mem_addr, 32'h0000_0100);
        check("t4 redirect req", {31'h0, bus0.mem_req}, 32'h1);
        check("t4 discarded", {31'h0, inst_valid}, 32'h0);
        step();
        check("t4 inst", inst, 32'hE3A0_0001);
        check("t4 inst_pc", inst_pc, 32'h100);

        // Test 2: condition-code table
        for (int i = 0; i < 18; i++) begin
            cpsr = vecs[i].cpsr;
            load_inst(vecs[i].inst);
            check($sformatf("vec%0d inst", i), inst, vecs[i].inst);
            check($sformatf("vec%0d cond_pass", i), {31'h0, cond_pass}, {31'h0, vecs[i].exp});
        end
        cpsr = '0;

        // Test 5: asynchronous reset, in HOLD then mid-request
        #2 reset = 1'b1;
        #1;
        check("async rst valid", {31'h0, inst_valid}, 32'h0);
        check("async rst inst", inst, Nop);
        check("async rst cond", {31'h0, cond_pass}, 32'h0);
        wait_states = 5;
        @(posedge clk); #1; reset = 1'b0;
        step();
        step();
        check("midreq req", {31'h0, bus0.mem_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midreq rst req drop", {31'h0, bus0.mem_req}, 32'h0);
        check("midreq rst valid", {31'h0, inst_valid}, 32'h0);
        @(posedge clk); #1; reset = 1'b0;
        force_ack = 1'b1;
        wait_states = 0;
        check("rel first cycle req", {31'h0, bus0.mem_req}, 32'h0);
        step();
        force_ack = 1'b0;
        check("early ack ignored", {31'h0, inst_valid}, 32'h0);
        check("rel req", {31'h0, bus0.mem_req}, 32'h1);
        check("rel addr", bus0.mem_addr, 32'h0);
        step();
        check("rel inst", inst, 32'hE201_1002);
        check("rel valid", {31'h0, inst_valid}, 32'h1);

`ifdef ARM_FETCH_ABORT_EN
        // Test 6: prefetch abort at 8
        check("abort reset", {31'h0, prefetch_abort}, 32'h0);
        pc_in = 32'h8; pc_we = 1'b1;
        step();
        pc_we = 1'b0;
        abort_in = 1'b1;
        check("ab addr", bus0.mem_addr, 32'h8);
        step();
        abort_in = 1'b0;
        check("ab flag", {31'h0, prefetch_abort}, 32'h1);
        check("ab inst", inst, Nop);
        check("ab valid", {31'h0, inst_valid}, 32'h1);
        check("ab cond", {31'h0, cond_pass}, 32'h0);
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("ab no req", {31'h0, bus0.mem_req}, 32'h0);
            check("ab held", {31'h0, prefetch_abort}, 32'h1);
        end
        stall = 1'b1;
        pc_in = 32'h0C; pc_we = 1'b1;
        step();
        pc_we = 1'b0;
        check("ab cleared", {31'h0, prefetch_abort}, 32'h0);
        check("ab refetch req", {31'h0, bus0.mem_req}, 32'h1);
        check("ab refetch addr", bus0.mem_addr, 32'h0C);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arm_fetch.md
Name: arm_fetch

Overview:
- Instruction fetch stage that produces the `inst` and `cond_pass` pair consumed by arm_decode.
- Holds a PC and issues word reads to instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register, together with its address.
- Evaluates the ARM condition field of the held instruction against the live CPSR flags.
- Accepts PC redirects (`pc_we`/`pc_in`) from the register file / writeback path.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  output  1  fetch request; held high until `mem_ack`.
- mem_addr  output  32  fetch address; word aligned, stable while `mem_req` is high.
- mem_ack  input  1  memory has `mem_rdata` valid this cycle.
- mem_rdata  input  32  instruction word.
- stall  input  1  decode/execute not ready; holds the current instruction.
- pc_we  input  1  redirect strobe, one cycle.
- pc_in  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- cpsr  input  32  current CPSR; N, Z, C, V are bits 31, 30, 29, 28.
- inst  output  32  held instruction, to decode.
- inst_pc  output  32  address of `inst`.
- inst_valid  output  1  `inst` is valid for decode.
- cond_pass  output  1  condition of `inst` is satisfied; forced 0 when `inst_valid` = 0.

Behaviour:
- Reset values:
  - state = FETCH, pc = RESET_PC, mem_req = 0.
  - inst = 32'hE1A0_0000 (NOP, MOV R0,R0), inst_pc = 0, inst_valid = 0, cond_pass = 0.
- Reset is asynchronous. A request outstanding at reset is abandoned: the memory must tolerate `mem_req` dropping. Any `mem_ack` in the first cycle after reset deassertion is ignored.
- `mem_addr` always equals the internal pc.
- States:
  - FETCH
    - `mem_req` = 1 (except the first cycle after reset).
    - On `mem_ack` with no `pc_we`:
      - inst ← mem_rdata, inst_pc ← pc, pc ← pc + PC_STEP.
      - inst_valid = 1 next cycle, next state HOLD.
    - On `pc_we` and `mem_ack` in the same cycle: data is discarded, pc ← pc_in, stay in FETCH.
    - On `pc_we` without `mem_ack`: latch pc_in into redirect register, go to FLUSH. `mem_req` and `mem_addr` stay unchanged.
  - FLUSH
    - `mem_req` = 1 on the old address.
    - On `mem_ack`: discard data, pc ← redirect target, go to FETCH.
    - A further `pc_we` in FLUSH overwrites the redirect target; the last one wins.
  - HOLD
    - `mem_req` = 0, inst_valid = 1.
    - If stall = 0 at the clock edge: the instruction is consumed, inst_valid ← 0, go to FETCH.
    - If `pc_we`: inst_valid ← 0, pc ← pc_in, go to FETCH. This takes priority over stall.
- Latency:
  - `mem_ack` in cycle N gives inst_valid in cycle N+1.
  - Minimum throughput with zero-wait memory is one instruction per 2 cycles.
- pc arithmetic is 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0.
- cond_pass is combinational from inst[31:28] and cpsr[31:28]:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; NV (4'b1111) 0.

Optional Feature:
- ARM_FETCH_ABORT_EN. When defined, adds:
  - input `mem_abort` (1): qualified by `mem_ack`.
  - output `prefetch_abort` (1): reset 0.
- On an ack with `mem_abort` = 1:
  - inst ← NOP, inst_valid ← 1, prefetch_abort ← 1, cond_pass forced 0.
  - pc is not advanced; the fetch unit waits in HOLD for a redirect.
  - Consuming the instruction (stall = 0) does not leave HOLD.
  - `pc_we` clears prefetch_abort and goes to FETCH.
- When not defined: neither port exists and every ack is treated as a good fetch.

Test Plan:
1. Zero-wait memory returns 32'hE201_1002 (AND R1,R1,#2) at 0, with cpsr = 0 -> mem_addr 0 then 4; inst = E2011002, inst_pc = 0, inst_valid 1 cycle after ack; cond_pass = 1 (AL).
2. inst 32'h0A00_0000 (BEQ): cpsr = 32'h4000_0000 -> cond_pass = 1; cpsr = 0 -> cond_pass = 0. Repeat with GT, LE and NV (NV always 0).
3. stall = 1 for 3 cycles in HOLD -> inst and inst_valid stable, mem_req = 0; stall = 0 -> next request to pc + 4 the following cycle.
4. `pc_we` with pc_in = 32'h0000_0103 while a 3-wait-state fetch is outstanding -> mem_addr unchanged until ack; returned data discarded (inst_valid stays 0); next mem_addr = 32'h0000_0100.
5. RESET_PC = 32'hFFFF_FFFC -> second fetch address 0. Reset asserted mid-request -> mem_req and inst_valid drop immediately; first fetch after release at RESET_PC.
6. (ARM_FETCH_ABORT_EN) ack with mem_abort at 8 -> prefetch_abort = 1, inst = E1A00000, cond_pass = 0, no new requests; pc_we = 32'h0C -> prefetch_abort = 0, fetch at 0C.
